// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data-memory load/store handshake, with programmable wait states.
// Optional range checking is enabled by defining DMEM_RANGE_CHECK_EN; otherwise addresses wrap modulo DEPTH.
module data_mem_responder #(
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    function automatic mem_t mem_init();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = (i < 8) ? DATA_W'(i) : '0;
        end
        return m;
    endfunction

    // Power-up image only; reset deliberately leaves the array untouched.
    mem_t mem_q = mem_init();

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              oob_q, oob_d;
    logic [DATA_W-1:0] rdata_q;

    logic              addr_oob;
    logic              commit;
    logic              commit_write;
    logic [AW-1:0]     commit_idx;
    logic [DATA_W-1:0] commit_wdata;
    logic              commit_oob;

`ifdef DMEM_RANGE_CHECK_EN
    assign addr_oob = (req_addr >= 32'(DEPTH));
`else
    logic unused_addr_hi;
    assign addr_oob       = 1'b0;
    assign unused_addr_hi = ^req_addr[31:AW];
`endif

    // commit marks the edge that enters RESP; with zero wait states the
    // request is committed straight from the input port on the accept edge.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        oob_d        = oob_q;
        commit       = 1'b0;
        commit_write = write_q;
        commit_idx   = idx_q;
        commit_wdata = wdata_q;
        commit_oob   = oob_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    idx_d   = req_addr[AW-1:0];
                    wdata_d = req_wdata;
                    oob_d   = addr_oob;
                    if (WAIT_CYCLES == 0) begin
                        state_d      = RESP;
                        commit       = 1'b1;
                        commit_write = req_write;
                        commit_idx   = req_addr[AW-1:0];
                        commit_wdata = req_wdata;
                        commit_oob   = addr_oob;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            oob_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            oob_q   <= oob_d;
            if (commit) begin
                rdata_q <= (commit_write || commit_oob) ? '0 : mem_q[commit_idx];
            end
        end
    end

    // A reset on the commit edge drops the pending store.
    always_ff @(posedge clk) begin
        if (!rst && commit && commit_write && !commit_oob) begin
            mem_q[commit_idx] <= commit_wdata;
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (commit) begin
            err_q <= commit_oob;
        end
    end
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_rdata = rdata_q;

endmodule
